// File: rtl/axi4_if.sv
// AXI4-Lite read-channel bundle.
// Master drives AR and rready; slave drives arready and R.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
);
  logic [A-1:0]   araddr;
  logic [I-1:0]   arid;
  logic           arvalid;
  logic           arready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;
  logic           rvalid;
  logic           rready;

  modport master (
    output araddr, arid, arvalid, rready,
    input  arready, rdata, rresp, rid, rvalid
  );

  modport slave (
    input  araddr, arid, arvalid, rready,
    output arready, rdata, rresp, rid, rvalid
  );
endinterface

// File: rtl/axi4_lite_arb_rd.sv
// Two-master to one-slave AXI4-Lite read arbiter.
// Round-robin AR into a one-entry slot; in-order grant FIFO steers R.
module axi4_lite_arb_rd #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1,
  parameter int D = 4
) (
  input  logic   aclk,
  input  logic   aresetn,
  axi4_if.slave  axi4_s [2],
  axi4_if.master axi4_m
);
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] CMAX = CW'(D);

  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [D-1:0]  gnt_q;
  logic          last_grant;

  logic          m_arvalid;
  logic [A-1:0]  m_araddr;
  logic [I-1:0]  m_arid;

  logic v0;
  logic v1;
  logic winner;
  logic slot_free;
  logic accept_ok;
  logic ar_hs;
  logic r_hs;
  logic empty;
  logic head;

  assign v0 = axi4_s[0].arvalid;
  assign v1 = axi4_s[1].arvalid;

  // A lone requester wins; a tie goes to whoever lost last time.
  assign winner    = (v0 & v1) ? ~last_grant : v1;
  assign slot_free = ~m_arvalid | axi4_m.arready;
  assign accept_ok = aresetn & slot_free & (cnt < CMAX);
  assign ar_hs     = accept_ok & (v0 | v1);

  assign axi4_s[0].arready = accept_ok & v0 & ~winner;
  assign axi4_s[1].arready = accept_ok & v1 & winner;

  assign axi4_m.araddr  = m_araddr;
  assign axi4_m.arid    = m_arid;
  assign axi4_m.arvalid = m_arvalid;

  assign empty = (cnt == '0);
  assign head  = gnt_q[rd_ptr];

  // R beats go only to the master at the FIFO head.
  assign axi4_s[0].rvalid = axi4_m.rvalid & ~empty & ~head;
  assign axi4_s[1].rvalid = axi4_m.rvalid & ~empty & head;

  assign axi4_s[0].rdata = axi4_m.rdata;
  assign axi4_s[1].rdata = axi4_m.rdata;
  assign axi4_s[0].rresp = axi4_m.rresp;
  assign axi4_s[1].rresp = axi4_m.rresp;
  assign axi4_s[0].rid   = axi4_m.rid;
  assign axi4_s[1].rid   = axi4_m.rid;

  assign axi4_m.rready = ~empty &
    (head ? axi4_s[1].rready : axi4_s[0].rready);
  assign r_hs = axi4_m.rvalid & axi4_m.rready;

  // AR slot: load on grant, clear when downstream takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_arid     <= '0;
      last_grant <= 1'b1;
    end else if (ar_hs) begin
      m_arvalid  <= 1'b1;
      m_araddr   <= winner ? axi4_s[1].araddr
                           : axi4_s[0].araddr;
      m_arid     <= winner ? axi4_s[1].arid
                           : axi4_s[0].arid;
      last_grant <= winner;
    end else if (axi4_m.arready) begin
      m_arvalid  <= 1'b0;
    end
  end

  // Grant FIFO and outstanding count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (ar_hs) begin
        gnt_q[wr_ptr] <= winner;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (r_hs) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({ar_hs, r_hs})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_arb_rd.sv
// Bench for axi4_lite_arb_rd.
// Downstream model plus in-order scoreboard of expected R beats.
module tb_axi4_lite_arb_rd;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(32), .N(4), .I(1)) s_if [2] ();
  axi4_if #(.A(32), .N(4), .I(1)) m_if ();

  axi4_lite_arb_rd #(.A(32), .N(4), .I(1), .D(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi4_s  (s_if),
    .axi4_m  (m_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m;
    logic [31:0] a;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        e0;
    logic        e1;
  } vec_t;
  vec_t tbl[10];

  logic        ds_arready = 1'b1;
  logic        ds_hold = 1'b0;
  logic        ds_force = 1'b0;
  logic        ds_rvalid = 1'b0;
  logic [31:0] ds_rdata = '0;
  logic [1:0]  ds_rresp = '0;
  logic [31:0] ds_q[$];
  logic        rr0 = 1'b1;
  logic        rr1 = 1'b1;

  assign m_if.arready   = ds_arready;
  assign m_if.rvalid    = ds_rvalid | ds_force;
  assign m_if.rdata     = ds_rdata;
  assign m_if.rresp     = ds_rresp;
  assign m_if.rid       = '0;
  assign s_if[0].arid   = '0;
  assign s_if[1].arid   = '0;
  assign s_if[0].rready = rr0;
  assign s_if[1].rready = rr1;

  function automatic logic [31:0] fdata(logic [31:0] a);
    return (a << 8) ^ 32'hA5;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(int m, logic [31:0] a);
    sb_t e;
    e.m = m;
    e.a = a;
    sb.push_back(e);
  endtask

  task automatic r_got(int j, logic [31:0] d, logic [1:0] r);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL r_unexpected: beat at m%0d data %0h", j, d);
    end else begin
      e = sb.pop_front();
      chk("r_master", j, e.m);
      chk("r_data", d, fdata(e.a));
      chk("r_resp", {30'd0, r}, {30'd0, e.a[9:8]});
    end
  endtask

  // Downstream slave: accepts AR, returns beats in order.
  logic        mdl_ar;
  logic        mdl_rh;
  logic [31:0] mdl_a;
  always @(posedge aclk) begin
    mdl_ar = m_if.arvalid & m_if.arready;
    mdl_rh = m_if.rvalid & m_if.rready;
    mdl_a  = m_if.araddr;
    #1;
    if (!aresetn) begin
      ds_q.delete();
    end else begin
      if (mdl_rh && ds_q.size() > 0) void'(ds_q.pop_front());
      if (mdl_ar) ds_q.push_back(mdl_a);
    end
    ds_rvalid = (ds_q.size() > 0) && !ds_hold;
    ds_rdata  = (ds_q.size() > 0) ? fdata(ds_q[0]) : '0;
    ds_rresp  = (ds_q.size() > 0) ? ds_q[0][9:8] : 2'd0;
  end

  // Upstream monitor: every delivered beat must match the queue head.
  always @(posedge aclk) begin
    if (aresetn) begin
      if (s_if[0].rvalid && s_if[0].rready)
        r_got(0, s_if[0].rdata, s_if[0].rresp);
      if (s_if[1].rvalid && s_if[1].rready)
        r_got(1, s_if[1].rdata, s_if[1].rresp);
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_if[0].arvalid = 1'b0;
    s_if[1].arvalid = 1'b0;
    s_if[0].araddr = '0;
    s_if[1].araddr = '0;
    ds_arready = 1'b1;
    ds_hold = 1'b0;
    ds_force = 1'b0;
    rr0 = 1'b1;
    rr1 = 1'b1;
    sb.delete();
    repeat (2) @(posedge aclk);
    #2;
    chk("rst_arready0", s_if[0].arready, 0);
    chk("rst_arready1", s_if[1].arready, 0);
    chk("rst_rvalid0", s_if[0].rvalid, 0);
    chk("rst_rvalid1", s_if[1].rvalid, 0);
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_m_araddr", m_if.araddr, 0);
    chk("rst_cnt", dut.cnt, 0);
    aresetn = 1'b1;
  endtask

  task automatic drain(string nm);
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h000, 32'h100, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h004, 32'h104, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h008, 32'h108, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h00C, 32'h10C, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h010, 32'h210, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h014, 32'h114, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h018, 32'h118, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h01C, 32'h31C, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 32'h020, 32'h120, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 32'h024, 32'h324, 1'b0, 1'b1};

    // Single read from m0.
    do_reset();
    cyc();
    s_if[0].arvalid = 1'b1;
    s_if[0].araddr = 32'h10;
    #1;
    chk("t1_arready0", s_if[0].arready, 1);
    chk("t1_arready1", s_if[1].arready, 0);
    push(0, 32'h10);
    cyc();
    s_if[0].arvalid = 1'b0;
    #1;
    chk("t1_m_arvalid", m_if.arvalid, 1);
    chk("t1_m_araddr", m_if.araddr, 32'h10);
    chk("t1_cnt1", dut.cnt, 1);
    cyc();
    #1;
    chk("t1_rvalid0", s_if[0].rvalid, 1);
    chk("t1_rvalid1", s_if[1].rvalid, 0);
    cyc();
    #1;
    chk("t1_cnt0", dut.cnt, 0);
    drain("t1_drain");

    // Arbitration table with continuous downstream service.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      s_if[0].arvalid = tbl[i].v0;
      s_if[1].arvalid = tbl[i].v1;
      s_if[0].araddr = tbl[i].a0;
      s_if[1].araddr = tbl[i].a1;
      #1;
      chk($sformatf("tbl%0d_rdy0", i), s_if[0].arready, tbl[i].e0);
      chk($sformatf("tbl%0d_rdy1", i), s_if[1].arready, tbl[i].e1);
      if (tbl[i].e0) push(0, tbl[i].a0);
      if (tbl[i].e1) push(1, tbl[i].a1);
    end
    cyc();
    s_if[0].arvalid = 1'b0;
    s_if[1].arvalid = 1'b0;
    drain("tbl_drain");

    // Back-pressure on the downstream AR slot.
    do_reset();
    ds_arready = 1'b0;
    cyc();
    s_if[0].arvalid = 1'b1;
    s_if[0].araddr = 32'h40;
    #1;
    chk("bp_first_rdy0", s_if[0].arready, 1);
    push(0, 32'h40);
    cyc();
    s_if[0].araddr = 32'h44;
    s_if[1].arvalid = 1'b1;
    s_if[1].araddr = 32'h144;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_arvalid", m_if.arvalid, 1);
      chk("bp_araddr", m_if.araddr, 32'h40);
      chk("bp_rdy0", s_if[0].arready, 0);
      chk("bp_rdy1", s_if[1].arready, 0);
      cyc();
    end
    ds_arready = 1'b1;
    #1;
    chk("bp_free_rdy1", s_if[1].arready, 1);
    chk("bp_free_rdy0", s_if[0].arready, 0);
    push(1, 32'h144);
    cyc();
    s_if[1].arvalid = 1'b0;
    #1;
    chk("bp_next_araddr", m_if.araddr, 32'h144);
    chk("bp_next_rdy0", s_if[0].arready, 1);
    push(0, 32'h44);
    cyc();
    s_if[0].arvalid = 1'b0;
    drain("bp_drain");

    // Outstanding limit of four.
    do_reset();
    ds_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      s_if[0].arvalid = 1'b1;
      s_if[0].araddr = 32'h10 + 32'(4 * k);
      #1;
      chk("lim_rdy0", s_if[0].arready, 1);
      push(0, 32'h10 + 32'(4 * k));
    end
    cyc();
    s_if[0].araddr = 32'h20;
    #1;
    chk("lim_cnt4", dut.cnt, 4);
    chk("lim_stall", s_if[0].arready, 0);
    cyc();
    #1;
    chk("lim_stall2", s_if[0].arready, 0);
    ds_hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      #1;
      if (s_if[0].rvalid) break;
    end
    chk("lim_wait_rvalid", s_if[0].rvalid, 1);
    chk("lim_stall3", s_if[0].arready, 0);
    cyc();
    #1;
    chk("lim_cnt3", dut.cnt, 3);
    chk("lim_resume", s_if[0].arready, 1);
    push(0, 32'h20);
    cyc();
    s_if[0].arvalid = 1'b0;
    drain("lim_drain");

    // Stray rvalid with nothing outstanding, then AR+R together.
    do_reset();
    ds_force = 1'b1;
    #1;
    chk("err_rvalid0", s_if[0].rvalid, 0);
    chk("err_rvalid1", s_if[1].rvalid, 0);
    chk("err_rready", m_if.rready, 0);
    ds_force = 1'b0;
    ds_hold = 1'b1;
    cyc();
    s_if[1].arvalid = 1'b1;
    s_if[1].araddr = 32'h200;
    #1;
    chk("sim_rdy1a", s_if[1].arready, 1);
    push(1, 32'h200);
    cyc();
    s_if[1].araddr = 32'h204;
    #1;
    chk("sim_rdy1b", s_if[1].arready, 1);
    push(1, 32'h204);
    cyc();
    s_if[1].arvalid = 1'b0;
    ds_hold = 1'b0;
    cyc();
    s_if[0].arvalid = 1'b1;
    s_if[0].araddr = 32'h30;
    #1;
    chk("sim_rvalid1", s_if[1].rvalid, 1);
    chk("sim_rdy0", s_if[0].arready, 1);
    chk("sim_cnt_pre", dut.cnt, 2);
    push(0, 32'h30);
    cyc();
    s_if[0].arvalid = 1'b0;
    #1;
    chk("sim_cnt_post", dut.cnt, 2);
    chk("sim_occ", 32'(2'(dut.wr_ptr - dut.rd_ptr)), 2);
    drain("sim_drain");

    // Reset while reads are in flight.
    do_reset();
    ds_hold = 1'b1;
    rr0 = 1'b0;
    cyc();
    s_if[0].arvalid = 1'b1;
    s_if[0].araddr = 32'h300;
    #1;
    chk("mr_rdy0a", s_if[0].arready, 1);
    cyc();
    s_if[0].arvalid = 1'b0;
    s_if[1].arvalid = 1'b1;
    s_if[1].araddr = 32'h304;
    #1;
    chk("mr_rdy1", s_if[1].arready, 1);
    cyc();
    s_if[1].arvalid = 1'b0;
    s_if[0].arvalid = 1'b1;
    s_if[0].araddr = 32'h308;
    #1;
    chk("mr_rdy0b", s_if[0].arready, 1);
    cyc();
    s_if[0].arvalid = 1'b0;
    ds_hold = 1'b0;
    cyc();
    cyc();
    s_if[0].arvalid = 1'b1;
    s_if[1].arvalid = 1'b1;
    s_if[0].araddr = 32'h50;
    s_if[1].araddr = 32'h150;
    #1;
    chk("mr_pend_rvalid0", s_if[0].rvalid, 1);
    chk("mr_pend_cnt", dut.cnt, 3);
    chk("mr_pend_rdy1", s_if[1].arready, 1);
    aresetn = 1'b0;
    sb.delete();
    #1;
    chk("mr_rvalid0", s_if[0].rvalid, 0);
    chk("mr_rvalid1", s_if[1].rvalid, 0);
    chk("mr_rdy0", s_if[0].arready, 0);
    chk("mr_rdy1_0", s_if[1].arready, 0);
    chk("mr_cnt", dut.cnt, 0);
    chk("mr_m_arvalid", m_if.arvalid, 0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    rr0 = 1'b1;
    #1;
    chk("mr_tie_rdy0", s_if[0].arready, 1);
    chk("mr_tie_rdy1", s_if[1].arready, 0);
    push(0, 32'h50);
    cyc();
    s_if[0].arvalid = 1'b0;
    s_if[1].arvalid = 1'b0;
    drain("mr_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
